// File: rtl/dual_port_memory.sv
// ----------------------------------------------------------------------------
// dual_port_memory
//
// Simple dual-port synchronous RAM: one write port and one read port sharing a
// single clock. Writes land when both the write request and the memory write
// enable are high and the address is in range. Reads are registered with one
// clock of latency and are qualified by a one-cycle data-valid strobe.
//
// Ports:
//   i_clk        - single clock, all state updates on the rising edge
//   i_rst_n      - synchronous active-low reset (clears output flops only)
//   i_data_in    - write data, RAM_WIDTH bits
//   i_rd_address - read address, ADDR_SIZE bits
//   i_wr_address - write address, ADDR_SIZE bits
//   i_read       - read request
//   i_write      - write request
//   i_mem_wr_en  - memory write enable, qualifies i_write
//   i_mem_rd_en  - memory read enable, qualifies i_read
//   o_data_out   - registered read data
//   o_data_valid - high for exactly the cycle after an accepted read
// ----------------------------------------------------------------------------
module dual_port_memory #(
    parameter int unsigned RAM_WIDTH = 64,
    parameter int unsigned RAM_DEPTH = 1024,
    parameter int unsigned ADDR_SIZE = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [RAM_WIDTH-1:0] i_data_in,
    input  logic [ADDR_SIZE-1:0] i_rd_address,
    input  logic [ADDR_SIZE-1:0] i_wr_address,
    input  logic                 i_read,
    input  logic                 i_write,
    input  logic                 i_mem_wr_en,
    input  logic                 i_mem_rd_en,
    output logic [RAM_WIDTH-1:0] o_data_out,
    output logic                 o_data_valid
);

    // Depth widened by one bit so RAM_DEPTH == 2**ADDR_SIZE is representable.
    localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE + 1)'(RAM_DEPTH);

    logic [RAM_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_data_out;
    logic                 r_data_valid;

    logic w_wr_in_range;
    logic w_rd_in_range;
    logic w_wr_accept;
    logic w_rd_accept;

    always_comb begin
        w_wr_in_range = ({1'b0, i_wr_address} < DEPTH_L);
        w_rd_in_range = ({1'b0, i_rd_address} < DEPTH_L);
        w_wr_accept   = i_rst_n && i_write && i_mem_wr_en && w_wr_in_range;
        w_rd_accept   = i_rst_n && i_read && i_mem_rd_en;
    end

    // Array has no reset: contents survive rst_n. Writes are suppressed on a
    // reset edge through w_wr_accept.
    always_ff @(posedge i_clk) begin
        if (w_wr_accept) begin
            r_mem[i_wr_address] <= i_data_in;
        end
    end

    // Read port. The array read uses the pre-edge contents, so a same-address
    // read/write collision returns the old data (read-first).
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else if (w_rd_accept) begin
            r_data_valid <= 1'b1;
            if (w_rd_in_range) begin
                r_data_out <= r_mem[i_rd_address];
            end else begin
                r_data_out <= '0;
            end
        end else begin
            // No accepted read: strobe drops, data holds.
            r_data_valid <= 1'b0;
        end
    end

    assign o_data_out   = r_data_out;
    assign o_data_valid = r_data_valid;

endmodule

// File: tb/tb_dual_port_memory.sv
// ----------------------------------------------------------------------------
// tb_dual_port_memory
//
// Directed bench for dual_port_memory. Instance u_dut uses the default
// 1024-word geometry; u_dut_small uses RAM_DEPTH=1000 for out-of-range checks.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same
// point, i.e. after the edge that produced them.
// ----------------------------------------------------------------------------
module tb_dual_port_memory;

    localparam int unsigned W = 64;
    localparam int unsigned A = 10;

    logic         clk;
    logic         rst_n;

    logic [W-1:0] data_in;
    logic [A-1:0] rd_address;
    logic [A-1:0] wr_address;
    logic         read;
    logic         write;
    logic         mem_wr_en;
    logic         mem_rd_en;
    logic [W-1:0] data_out;
    logic         data_valid;

    logic [W-1:0] s_data_in;
    logic [A-1:0] s_rd_address;
    logic [A-1:0] s_wr_address;
    logic         s_read;
    logic         s_write;
    logic [W-1:0] s_data_out;
    logic         s_data_valid;

    int errors = 0;
    int checks = 0;

    localparam logic [W-1:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] DEAD = 64'hDEAD_BEEF_CAFE_BABE;

    dual_port_memory #(
        .RAM_WIDTH(W),
        .RAM_DEPTH(1024),
        .ADDR_SIZE(A)
    ) u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data_in   (data_in),
        .i_rd_address(rd_address),
        .i_wr_address(wr_address),
        .i_read      (read),
        .i_write     (write),
        .i_mem_wr_en (mem_wr_en),
        .i_mem_rd_en (mem_rd_en),
        .o_data_out  (data_out),
        .o_data_valid(data_valid)
    );

    dual_port_memory #(
        .RAM_WIDTH(W),
        .RAM_DEPTH(1000),
        .ADDR_SIZE(A)
    ) u_dut_small (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data_in   (s_data_in),
        .i_rd_address(s_rd_address),
        .i_wr_address(s_wr_address),
        .i_read      (s_read),
        .i_write     (s_write),
        .i_mem_wr_en (1'b1),
        .i_mem_rd_en (1'b1),
        .o_data_out  (s_data_out),
        .o_data_valid(s_data_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        data_in      = '0;
        rd_address   = '0;
        wr_address   = '0;
        read         = 1'b0;
        write        = 1'b0;
        mem_wr_en    = 1'b0;
        mem_rd_en    = 1'b0;
        s_data_in    = '0;
        s_rd_address = '0;
        s_wr_address = '0;
        s_read       = 1'b0;
        s_write      = 1'b0;

        // Reset for two cycles.
        tick();
        tick();
        check("rst_out", data_out, '0);
        check("rst_valid", {63'd0, data_valid}, 64'd1 - 64'd1);
        check("rst_small_valid", {63'd0, s_data_valid}, '0);
        rst_n = 1'b1;

        // Basic write then read of address 10.
        write = 1'b1; mem_wr_en = 1'b1; wr_address = 10; data_in = DEAD;
        tick();
        write = 1'b0; mem_wr_en = 1'b0;
        read = 1'b1; mem_rd_en = 1'b1; rd_address = 10;
        tick();
        check("rd10_out", data_out, DEAD);
        check("rd10_valid", {63'd0, data_valid}, 64'd1);
        read = 1'b0; mem_rd_en = 1'b0;
        tick();
        check("idle_valid", {63'd0, data_valid}, '0);
        check("idle_hold", data_out, DEAD);

        // Write blocked by mem_wr_en=0.
        write = 1'b1; mem_wr_en = 1'b0; wr_address = 10; data_in = 64'h1111;
        tick();
        write = 1'b0;
        // Read blocked by mem_rd_en=0.
        read = 1'b1; mem_rd_en = 1'b0; rd_address = 10;
        tick();
        check("rden0_valid", {63'd0, data_valid}, '0);
        check("rden0_hold", data_out, DEAD);
        mem_rd_en = 1'b1;
        tick();
        check("wren0_data", data_out, DEAD);
        check("wren0_valid", {63'd0, data_valid}, 64'd1);
        read = 1'b0; mem_rd_en = 1'b0;

        // Same-address collision is read-first.
        write = 1'b1; mem_wr_en = 1'b1; wr_address = 5; data_in = 64'hA;
        tick();
        data_in = 64'hB;
        read = 1'b1; mem_rd_en = 1'b1; rd_address = 5;
        tick();
        check("coll_old", data_out, 64'hA);
        check("coll_valid", {63'd0, data_valid}, 64'd1);
        write = 1'b0; mem_wr_en = 1'b0;
        tick();
        check("coll_new", data_out, 64'hB);
        read = 1'b0; mem_rd_en = 1'b0;

        // Boundary addresses and back-to-back reads.
        write = 1'b1; mem_wr_en = 1'b1; wr_address = 0; data_in = '0;
        tick();
        wr_address = 1023; data_in = ONES;
        tick();
        write = 1'b0; mem_wr_en = 1'b0;
        read = 1'b1; mem_rd_en = 1'b1; rd_address = 1023;
        tick();
        check("str0_out", data_out, ONES);
        check("str0_valid", {63'd0, data_valid}, 64'd1);
        rd_address = 0;
        tick();
        check("str1_out", data_out, '0);
        check("str1_valid", {63'd0, data_valid}, 64'd1);
        rd_address = 1023;
        tick();
        check("str2_out", data_out, ONES);
        check("str2_valid", {63'd0, data_valid}, 64'd1);
        read = 1'b0; mem_rd_en = 1'b0;
        tick();
        check("str_end_valid", {63'd0, data_valid}, '0);

        // Reset on an edge that also carries a read and a write.
        rst_n = 1'b0;
        read = 1'b1; mem_rd_en = 1'b1; rd_address = 1023;
        write = 1'b1; mem_wr_en = 1'b1; wr_address = 0; data_in = 64'h1234;
        tick();
        check("midrst_out", data_out, '0);
        check("midrst_valid", {63'd0, data_valid}, '0);
        rst_n = 1'b1;
        write = 1'b0; mem_wr_en = 1'b0;
        rd_address = 1023;
        tick();
        check("post_rst_1023", data_out, ONES);
        rd_address = 0;
        tick();
        check("post_rst_0", data_out, '0);
        check("post_rst_valid", {63'd0, data_valid}, 64'd1);
        read = 1'b0; mem_rd_en = 1'b0;

        // Out-of-range on the 1000-word instance.
        s_write = 1'b1; s_wr_address = 999; s_data_in = 64'h77;
        tick();
        s_wr_address = 10; s_data_in = 64'h99;
        tick();
        s_wr_address = 1010; s_data_in = 64'h5;
        tick();
        s_write = 1'b0;
        s_read = 1'b1; s_rd_address = 999;
        tick();
        check("oor_pre_999", s_data_out, 64'h77);
        s_rd_address = 1010;
        tick();
        check("oor_rd_out", s_data_out, '0);
        check("oor_rd_valid", {63'd0, s_data_valid}, 64'd1);
        s_rd_address = 999;
        tick();
        check("oor_keep_999", s_data_out, 64'h77);
        s_rd_address = 10;
        tick();
        check("oor_keep_10", s_data_out, 64'h99);
        s_read = 1'b0;
        tick();
        check("oor_idle_valid", {63'd0, s_data_valid}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dual_port_memory.md
Name: dual_port_memory

Overview:
Simple dual-port synchronous RAM with one write port and one read port sharing a single clock. Writes are gated by a port enable and a memory enable. Reads are registered and qualified by a one-cycle data_valid strobe. Used as a generic buffer/storage block inside the SoC datapath.

Parameters:
RAM_WIDTH, 64, data word width in bits
RAM_DEPTH, 1024, number of words stored; must be <= 2**ADDR_SIZE
ADDR_SIZE, 10, address width in bits for both ports

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset
data_in  input  RAM_WIDTH  write data
rd_address  input  ADDR_SIZE  read address
wr_address  input  ADDR_SIZE  write address
read  input  1  read request
write  input  1  write request
mem_wr_en  input  1  memory write enable; qualifies write
mem_rd_en  input  1  memory read enable; qualifies read
data_out  output  RAM_WIDTH  registered read data
data_valid  output  1  high for exactly the cycle after an accepted read

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk.
  - While rst_n=0 at a clock edge: data_out <= 0, data_valid <= 0. Reads and writes are ignored on that edge.
  - Array contents are not cleared by reset and are retained across it.
- Write acceptance: on a rising edge with rst_n=1, write=1, mem_wr_en=1 and wr_address < RAM_DEPTH: mem[wr_address] <= data_in.
  - If either enable is low, nothing is written.
- Read acceptance: on a rising edge with rst_n=1, read=1, mem_rd_en=1:
  - data_out <= mem[rd_address] and data_valid <= 1.
  - Latency: 1 clock. Data and valid appear after the edge that samples the request.
- No accepted read on an edge: data_valid <= 0 and data_out holds its previous value.
- Out-of-range read (rd_address >= RAM_DEPTH): data_out <= 0, data_valid <= 1.
- Out-of-range write (wr_address >= RAM_DEPTH): dropped, no side effects.
- Read and write on the same edge to different addresses: both complete independently.
- Read and write on the same edge to the same address: read-first. data_out returns the pre-write contents; the new data is visible to reads on subsequent edges.
- Back-to-back reads on consecutive edges: data_valid stays high continuously and data_out updates every cycle.
- Uninitialised locations: contents undefined (X in simulation) until written. Benches must not check unwritten locations.
- No combinational path from any input to any output. All outputs are flops.
- Reset asserted mid-operation:
  - A read requested on the reset edge produces no data_valid.
  - A write on the reset edge is discarded.
  - Earlier completed writes remain intact.

Test Plan:
- Reset then write/read: rst_n low 2 cycles. Write 64'hDEADBEEFCAFEBABE to address 10 (write=1, mem_wr_en=1, one cycle). Next cycle read address 10 (read=1, mem_rd_en=1, one cycle) -> one cycle later data_out=64'hDEADBEEFCAFEBABE and data_valid=1; the cycle after, data_valid=0 and data_out holds.
- Enable gating: write=1 with mem_wr_en=0 of 64'h1111 to address 10 after the above -> reading address 10 still returns 64'hDEADBEEFCAFEBABE. Read=1 with mem_rd_en=0 -> data_valid stays 0 and data_out unchanged.
- Same-address collision: address 5 holds 64'hA. Same edge: write 64'hB to address 5 and read address 5 -> data_out=64'hA with data_valid=1. A read on the next edge returns 64'hB.
- Streaming and boundaries: write addresses 0 and 1023 with 64'h0 and 64'hFFFF_FFFF_FFFF_FFFF, then issue back-to-back reads of 1023, 0, 1023 -> data_valid high for 3 consecutive cycles with the matching data each cycle.
- Reset mid-operation: assert rst_n=0 on an edge carrying a read of address 1023 and a write to address 0 -> data_out=0, data_valid=0. After release, address 0 still reads 64'h0 and address 1023 still reads all-ones.
- Out-of-range (RAM_DEPTH=1000, ADDR_SIZE=10): write 64'h5 to address 1010, then read address 1010 -> data_out=0, data_valid=1. No in-range location is modified.
